mult_ctrl: RTL and testbench

Multi-cycle multiply controller owning the CPU's HI/LO register pair. Accepts MULT/MULTU requests from the execute stage and runs a 32-iteration radix-2 shift-add sequence on operand magnitudes, then applies a sign fix-up and commits the 64-bit product to HI/LO. It drives `busy` so the pipeline can stall MFHI/MFLO and new multiplies, handles MTHI/MTLO writes, and supports flush for exceptions.

---
 rtl/mult_ctrl.sv | 107 ++++++++++
 tb/tb_mult_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mult_ctrl.sv
// Multi-cycle HI/LO multiply controller: radix-2 shift-add on operand magnitudes,
// sign fix-up, 64-bit commit to HI/LO, plus MTHI/MTLO writes and flush abort.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no multiply in flight; accepts start and MTHI/MTLO writes
// CALC  | one shift-add iteration per clock, WIDTH iterations total
// FIX   | apply sign to the magnitude product and commit to HI/LO
module mult_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     ma;
    logic                 neg;
    logic [2*WIDTH-1:0]   p;
    logic [CNT_W-1:0]     cnt;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   product;

    // Negating the most negative value wraps back to itself, which is the
    // correct magnitude when read as unsigned.
    always_comb begin
        a_mag   = (is_signed && a[WIDTH-1]) ? -a : a;
        b_mag   = (is_signed && b[WIDTH-1]) ? -b : b;
        addend  = p[0] ? ma : '0;
        sum     = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        product = neg ? -p : p;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ma    <= '0;
            neg   <= 1'b0;
            p     <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start && !flush) begin
                        ma    <= a_mag;
                        neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        p     <= {{WIDTH{1'b0}}, b_mag};
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        p   <= {sum, p[WIDTH-1:1]};
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!flush) begin
                        hi   <= product[2*WIDTH-1:WIDTH];
                        lo   <= product[WIDTH-1:0];
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_ctrl.sv
// Directed bench for mult_ctrl: products, latency, busy/done timing, start
// while busy, flush, async reset and MTHI/MTLO behaviour.
module tb_mult_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    mult_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one start for a single edge (that edge is E0).
    task automatic launch(input logic s, input logic [31:0] av, input logic [31:0] bv);
        start     = 1'b1;
        is_signed = s;
        a         = av;
        b         = bv;
        tick();
        start     = 1'b0;
    endtask

    // Counts edges until done is seen; n = 0 means the bound expired.
    task automatic wait_done(output int n, output logic busy_gap);
        n        = 0;
        busy_gap = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                n = i;
                break;
            end
            if (!busy) busy_gap = 1'b1;
        end
    endtask

    task automatic run_mult(input string tag, input logic s, input logic [31:0] av,
                            input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo);
        int   n;
        logic gap;
        launch(s, av, bv);
        wait_done(n, gap);
        check({tag, " latency"}, 64'(n), 64'd33);
        check({tag, " busy_gap"}, 64'(gap), 64'd0);
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(ehi));
        check({tag, " lo"}, 64'(lo), 64'(elo));
    endtask

    initial begin
        int   n;
        logic gap;
        logic seen_done;

        reset = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) tick();
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        reset = 1'b1;
        tick();

        run_mult("umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        tick();
        check("umax done_width", 64'(done), 64'd0);

        run_mult("s7xm3", 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_mult("smin2", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_mult("sm1x1", 1'b1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_mult("u_ffx2", 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
        run_mult("s_ffx2", 1'b1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        // Async reset mid-CALC, sampled between edges.
        launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) tick();
        #2 reset = 1'b0;
        #1;
        check("areset hi", 64'(hi), 64'd0);
        check("areset lo", 64'(lo), 64'd0);
        check("areset busy", 64'(busy), 64'd0);
        check("areset done", 64'(done), 64'd0);
        tick();
        reset = 1'b1;
        tick();

        // Start while busy is ignored; start in the done cycle is accepted.
        launch(1'b0, 32'd5, 32'd6);
        repeat (9) tick();
        launch(1'b0, 32'd3, 32'd4);
        wait_done(n, gap);
        check("ign latency", 64'(n), 64'd23);
        check("ign hi", 64'(hi), 64'd0);
        check("ign lo", 64'(lo), 64'd30);
        launch(1'b0, 32'd3, 32'd4);
        wait_done(n, gap);
        check("b2b latency", 64'(n), 64'd33);
        check("b2b lo", 64'(lo), 64'd12);

        // MTHI in IDLE.
        hi_we = 1'b1; wdata = 32'h1234_5678;
        tick();
        hi_we = 1'b0;
        check("mthi hi", 64'(hi), 64'h1234_5678);

        // Preset both, then flush at cycle 12.
        hi_we = 1'b1; wdata = 32'h1111_1111;
        tick();
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h2222_2222;
        tick();
        lo_we = 1'b0;
        launch(1'b0, 32'd9, 32'd9);
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen_done = 1'b1;
            tick();
        end
        check("flush no_done", 64'(seen_done), 64'd0);
        check("flush hi", 64'(hi), 64'h1111_1111);
        check("flush lo", 64'(lo), 64'h2222_2222);

        // MTHI during CALC is ignored.
        launch(1'b0, 32'd5, 32'd6);
        repeat (4) tick();
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        tick();
        hi_we = 1'b0;
        check("calc_we hi_stable", 64'(hi), 64'h1111_1111);
        wait_done(n, gap);
        check("calc_we latency", 64'(n + 5), 64'd33);
        check("calc_we hi", 64'(hi), 64'd0);
        check("calc_we lo", 64'(lo), 64'd30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
